btb_update: RTL and testbench
=============================

BTB_UPDATE -- requirements
Module: btb_update

Interface
REQ-001 The block SHALL have one parameter: ALLOC_STATE, default `WEAK_TAKEN (2'b11), giving the 2-bit predictor state written into a newly allocated entry.
REQ-002 The block SHALL have one clock, clk, and reset SHALL be asynchronous and active-high on rst.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, asynchronous active-high reset
- update_valid, in, 1, EX-stage resolved branch this cycle
- update_pc, in, 32, branch PC: tag = [31:5], index = [4:2]
- update_target, in, 32, resolved branch target
- update_taken, in, 1, resolved direction
- flush, in, 1, synchronous invalidate of the whole BTB
- read_index, in, 3, IF-stage set index
- read_hit, in, 1, IF-stage lookup hit
- next_LRU_read, in, 1, IF-stage LRU value for read_index
- read_set, out, 128, set at read_index
- LRU, out, 8, per-set MRU way bits
- commit_valid, out, 1, one-cycle pulse when stage U2 writes the array

Function
REQ-004 Storage SHALL be 8 sets x 128 bits, with way1 = [127:64] and way2 = [63:0]; each way SHALL be: valid [63], tag [62:36], target [35:4], state [3:2], and [1:0] written as 0.
REQ-005 An update SHALL take two cycles:
- U1 registers the request and reads the indexed set.
- U2 computes the new set and writes it at the clock edge ending U2.
REQ-006 A new request SHALL be accepted every cycle, with no back-pressure.
REQ-007 If U1 and U2 hold the same index, U1 SHALL use U2's write data instead of the array contents.
REQ-008 Hit: the way that is valid with a matching tag (way1 has priority) SHALL have its state stepped by a saturating 2-bit counter:
- taken path: SNT(00) -> WNT(01) -> WT(11) -> ST(10), with ST held
- not-taken path: ST -> WT -> WNT -> SNT, with SNT held
REQ-009 On a hit with update_taken=1 the target SHALL be overwritten; on a not-taken hit the target SHALL be unchanged.
REQ-010 Hit with update_taken=1: LRU[index] SHALL be set to the hit way (0 = way1, 1 = way2).
REQ-011 Miss with update_taken=1 SHALL allocate: an invalid way is chosen first (way1 preferred); otherwise the victim is way2 if LRU[index]=0 and way1 if LRU[index]=1.
REQ-012 An allocated way SHALL be written with valid=1, tag, target and ALLOC_STATE, and LRU[index] SHALL point to it.
REQ-013 Miss with update_taken=0 SHALL leave the array and LRU unchanged, and commit_valid SHALL stay 0.
REQ-014 When read_hit=1 and no commit to the same index occurs, LRU[read_index] SHALL load next_LRU_read at the clock edge.
REQ-015 When an IF LRU write and a U2 commit target the same index in the same cycle, the commit SHALL win.
REQ-016 read_set SHALL be combinational from the array at read_index.
REQ-017 flush SHALL clear every valid bit and all LRU bits at the next edge, discard any U1/U2 request in that cycle, and take priority over commits.

Reset
REQ-018 rst SHALL asynchronously clear the array, LRU, and the U1/U2 valid flags to 0; commit_valid SHALL read 0 and read_set SHALL read 0 while rst is asserted.
REQ-019 An update in flight when rst asserts SHALL be discarded and never committed.

Configuration
REQ-020 With BTB_WRITE_BYPASS_EN defined and a U2 commit to read_index in the current cycle, read_set SHALL present the post-commit set in that same cycle.
REQ-021 Without BTB_WRITE_BYPASS_EN, read_set SHALL present the pre-commit array contents; latency and behaviour SHALL otherwise be unchanged.

Structure
REQ-022 The state encodings (STRONG_NOT_TAKEN, WEAK_NOT_TAKEN, STRONG_TAKEN, WEAK_TAKEN) and the way field bit positions SHALL live in the shared defines file, shared with the IF-stage reader.
REQ-023 The next-set computation (hit detection, counter step, victim select, new LRU bit) SHALL be one combinational sub-module, btb_set_update.
REQ-024 The top level SHALL hold only the storage, LRU, pipeline registers, bypass and arbitration.

Verification
REQ-025 Reset, then a taken update at PC=0x0000_0104 with target 0x0000_0200:
- two cycles later, way1 of set 1 SHALL be valid, tag 0x000_0008, target 0x200, state 11
- LRU[1] SHALL be 0
- commit_valid SHALL pulse once
REQ-026 Four further taken updates to the same PC SHALL give states 10, 10, 10, 10; then three not-taken updates SHALL give 11, 01, 00.
REQ-027 Taken updates to PCs 0x104, 0x124 and 0x144 (all set 1, distinct tags):
- the third SHALL evict way1 (LRU[1]=1 after the second)
- set 1 SHALL then hold 0x144's tag in way1 and 0x124's tag in way2
REQ-028 Back-to-back taken updates to 0x104 on consecutive cycles from state 01 SHALL end at state 10 (forwarding), not 11.
REQ-029 read_hit=1, read_index=1, next_LRU_read=1 in the same cycle as a commit to set 1 setting LRU=0: LRU[1] SHALL read 0 afterwards.
REQ-030 Flush and reset corner cases:
- flush asserted while a taken update sits in U1 SHALL leave all valid bits 0 with no commit
- rst pulsed mid-U2 SHALL leave set contents 0
- with BTB_WRITE_BYPASS_EN, read_set SHALL equal the new set during the commit cycle

Source files
------------

// File: rtl/btb_update_pkg.sv
// Shared BTB definitions: predictor state encodings, way field layout, counter step.
// Used by the EX-stage updater and the IF-stage reader.
package btb_update_pkg;

  localparam logic [1:0] STRONG_NOT_TAKEN = 2'b00;
  localparam logic [1:0] WEAK_NOT_TAKEN   = 2'b01;
  localparam logic [1:0] WEAK_TAKEN       = 2'b11;
  localparam logic [1:0] STRONG_TAKEN     = 2'b10;

  localparam int BTB_SETS = 8;
  localparam int TAG_W    = 27;

  // Bit positions within one 64-bit way; way1 sits at +64 in the set.
  localparam int WAY_VALID_BIT = 63;
  localparam int WAY_TAG_MSB   = 62;
  localparam int WAY_TAG_LSB   = 36;
  localparam int WAY_TGT_MSB   = 35;
  localparam int WAY_TGT_LSB   = 4;
  localparam int WAY_ST_MSB    = 3;
  localparam int WAY_ST_LSB    = 2;
  localparam int WAY1_VALID_BIT = WAY_VALID_BIT + 64;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       state;
    logic [1:0]       rsvd;
  } btb_way_t;

  typedef struct packed {
    btb_way_t way1;
    btb_way_t way2;
  } btb_set_t;

  function automatic logic [1:0] ctr_step(input logic [1:0] st, input logic taken);
    logic [1:0] nxt;
    nxt = st;
    if (taken) begin
      case (st)
        STRONG_NOT_TAKEN: nxt = WEAK_NOT_TAKEN;
        WEAK_NOT_TAKEN:   nxt = WEAK_TAKEN;
        default:          nxt = STRONG_TAKEN;
      endcase
    end else begin
      case (st)
        STRONG_TAKEN:   nxt = WEAK_TAKEN;
        WEAK_TAKEN:     nxt = WEAK_NOT_TAKEN;
        default:        nxt = STRONG_NOT_TAKEN;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_set_update.sv
// btb_set_update: combinational next-set computation (hit detect, counter step, victim, LRU).
// Zero latency, no flow control; do_write low means the set is left untouched.
module btb_set_update
  import btb_update_pkg::*;
#(
  parameter logic [1:0] ALLOC_STATE = WEAK_TAKEN
) (
  input  logic [127:0]     cur_set,
  input  logic [TAG_W-1:0] tag,
  input  logic [31:0]      target,
  input  logic             taken,
  input  logic             lru_bit,
  output logic [127:0]     new_set,
  output logic             new_lru,
  output logic             do_write
);

  btb_set_t cur;
  btb_set_t nxt;
  btb_way_t upd_way;
  logic     hit1;
  logic     hit2;
  logic     use_way2;

  always_comb begin
    cur      = cur_set;
    hit1     = cur.way1.valid && (cur.way1.tag == tag);
    hit2     = !hit1 && cur.way2.valid && (cur.way2.tag == tag);
    nxt      = cur;
    new_lru  = lru_bit;
    do_write = 1'b0;
    use_way2 = 1'b0;
    upd_way  = cur.way1;

    if (hit1 || hit2) begin
      use_way2      = hit2;
      upd_way       = hit2 ? cur.way2 : cur.way1;
      upd_way.state = ctr_step(upd_way.state, taken);
      upd_way.rsvd  = 2'b00;
      if (taken) begin
        upd_way.target = target;
        new_lru        = hit2;
      end
      do_write = 1'b1;
    end else if (taken) begin
      // Free way first; with both valid, evict the way that is not MRU.
      if (!cur.way1.valid)      use_way2 = 1'b0;
      else if (!cur.way2.valid) use_way2 = 1'b1;
      else                      use_way2 = !lru_bit;
      upd_way  = '{valid: 1'b1, tag: tag, target: target, state: ALLOC_STATE, rsvd: 2'b00};
      new_lru  = use_way2;
      do_write = 1'b1;
    end

    if (do_write) begin
      if (use_way2) nxt.way2 = upd_way;
      else          nxt.way1 = upd_way;
    end
    new_set = nxt;
  end

endmodule

// File: rtl/btb_update.sv
// btb_update: 8x2-way BTB with a two-stage update pipe (U1 read, U2 write); one update per cycle, no back-pressure.
// Define BTB_WRITE_BYPASS_EN to have read_set show the post-commit set during a commit to read_index.
module btb_update
  import btb_update_pkg::*;
#(
  parameter logic [1:0] ALLOC_STATE = WEAK_TAKEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         update_valid,
  input  logic [31:0]  update_pc,
  input  logic [31:0]  update_target,
  input  logic         update_taken,
  input  logic         flush,
  input  logic [2:0]   read_index,
  input  logic         read_hit,
  input  logic         next_LRU_read,
  output logic [127:0] read_set,
  output logic [7:0]   LRU,
  output logic         commit_valid
);

  logic [127:0]     btb_mem [BTB_SETS];

  logic             u1_vld;
  logic [2:0]       u1_index;
  logic [TAG_W-1:0] u1_tag;
  logic [31:0]      u1_target;
  logic             u1_taken;
  logic [127:0]     u1_set;

  logic             u2_vld;
  logic [2:0]       u2_index;
  logic [TAG_W-1:0] u2_tag;
  logic [31:0]      u2_target;
  logic             u2_taken;
  logic [127:0]     u2_set;

  logic [127:0]     u2_new_set;
  logic             u2_new_lru;
  logic             u2_write;
  logic             commit;

  logic             unused_pc_bits;
  assign unused_pc_bits = ^update_pc[1:0];

  btb_set_update #(.ALLOC_STATE(ALLOC_STATE)) u_set_update (
    .cur_set  (u2_set),
    .tag      (u2_tag),
    .target   (u2_target),
    .taken    (u2_taken),
    .lru_bit  (LRU[u2_index]),
    .new_set  (u2_new_set),
    .new_lru  (u2_new_lru),
    .do_write (u2_write)
  );

  assign commit       = u2_vld && u2_write && !flush;
  assign commit_valid = commit;

  // U1 must see the set U2 is about to write, otherwise back-to-back updates lose a step.
  assign u1_set = (commit && (u2_index == u1_index)) ? u2_new_set : btb_mem[u1_index];

  always_comb begin
    read_set = btb_mem[read_index];
`ifdef BTB_WRITE_BYPASS_EN
    if (commit && (u2_index == read_index)) read_set = u2_new_set;
`endif
    if (rst) read_set = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u1_vld    <= 1'b0;
      u1_index  <= '0;
      u1_tag    <= '0;
      u1_target <= '0;
      u1_taken  <= 1'b0;
      u2_vld    <= 1'b0;
      u2_index  <= '0;
      u2_tag    <= '0;
      u2_target <= '0;
      u2_taken  <= 1'b0;
      u2_set    <= '0;
    end else begin
      u1_vld    <= update_valid && !flush;
      u1_index  <= update_pc[4:2];
      u1_tag    <= update_pc[31:5];
      u1_target <= update_target;
      u1_taken  <= update_taken;
      u2_vld    <= u1_vld && !flush;
      u2_index  <= u1_index;
      u2_tag    <= u1_tag;
      u2_target <= u1_target;
      u2_taken  <= u1_taken;
      u2_set    <= u1_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_SETS; i++) btb_mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < BTB_SETS; i++) begin
        btb_mem[i][WAY1_VALID_BIT] <= 1'b0;
        btb_mem[i][WAY_VALID_BIT]  <= 1'b0;
      end
    end else if (commit) begin
      btb_mem[u2_index] <= u2_new_set;
    end
  end

  // The commit write is last so it overrides an IF-stage write to the same set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LRU <= '0;
    end else if (flush) begin
      LRU <= '0;
    end else begin
      if (read_hit) LRU[read_index] <= next_LRU_read;
      if (commit)   LRU[u2_index]   <= u2_new_lru;
    end
  end

endmodule

// File: tb/tb_btb_update.sv
// Scoreboard bench for btb_update: a reference model predicts each commit when the update is driven,
// and the commit monitor compares set contents and LRU when commit_valid fires.
module tb_btb_update;

  logic         clk = 1'b0;
  logic         rst;
  logic         update_valid;
  logic [31:0]  update_pc;
  logic [31:0]  update_target;
  logic         update_taken;
  logic         flush;
  logic [2:0]   read_index;
  logic         read_hit;
  logic         next_LRU_read;
  logic [127:0] read_set;
  logic [7:0]   LRU;
  logic         commit_valid;

  always #5 clk = ~clk;

  btb_update dut (
    .clk           (clk),
    .rst           (rst),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken),
    .flush         (flush),
    .read_index    (read_index),
    .read_hit      (read_hit),
    .next_LRU_read (next_LRU_read),
    .read_set      (read_set),
    .LRU           (LRU),
    .commit_valid  (commit_valid)
  );

  typedef struct {
    logic [2:0]   idx;
    logic [127:0] old_set;
    logic [127:0] new_set;
    logic         lru_bit;
  } sb_item_t;

  sb_item_t     sb_q[$];
  sb_item_t     pend;
  logic         pend_vld = 1'b0;
  logic [127:0] m_arr [8];
  logic [7:0]   m_lru;
  int           n_chk = 0;
  int           n_err = 0;
  int           n_commits = 0;
  int           base_commits;
  logic [127:0] s;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Counter step written as a plain transition table.
  function automatic logic [1:0] step_ref(input logic [1:0] st, input logic tk);
    case ({tk, st})
      3'b100:  return 2'b01;
      3'b101:  return 2'b11;
      3'b111:  return 2'b10;
      3'b110:  return 2'b10;
      3'b010:  return 2'b11;
      3'b011:  return 2'b01;
      3'b001:  return 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    logic [2:0]  ix;
    logic [26:0] tg;
    logic [63:0] w [2];
    logic [63:0] nw;
    int          sel;
    sb_item_t    it;
    ix   = pc[4:2];
    tg   = pc[31:5];
    w[0] = m_arr[ix][127:64];
    w[1] = m_arr[ix][63:0];
    sel  = -1;
    if (w[0][63] && w[0][62:36] == tg)      sel = 0;
    else if (w[1][63] && w[1][62:36] == tg) sel = 1;
    it.idx     = ix;
    it.old_set = m_arr[ix];
    if (sel >= 0) begin
      nw = w[sel];
      nw[3:2] = step_ref(nw[3:2], tk);
      if (tk) begin
        nw[35:4]  = tgt;
        m_lru[ix] = (sel == 1);
      end
    end else if (tk) begin
      if (!w[0][63])      sel = 0;
      else if (!w[1][63]) sel = 1;
      else                sel = m_lru[ix] ? 0 : 1;
      nw = {1'b1, tg, tgt, 2'b11, 2'b00};
      m_lru[ix] = (sel == 1);
    end else begin
      return;
    end
    w[sel]      = nw;
    m_arr[ix]   = {w[0], w[1]};
    it.new_set  = m_arr[ix];
    it.lru_bit  = m_lru[ix];
    sb_q.push_back(it);
  endtask

  // One clock: monitor at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    logic [2:0] ri;
    @(negedge clk);
    ri = read_index;
    if (pend_vld) begin
      pend_vld   = 1'b0;
      read_index = pend.idx;
      #1;
`ifndef BTB_WRITE_BYPASS_EN
      check($sformatf("set_after_commit[%0d]", pend.idx), read_set, pend.new_set);
`endif
      check($sformatf("lru_after_commit[%0d]", pend.idx), LRU[pend.idx], pend.lru_bit);
      read_index = ri;
    end
    if (commit_valid) begin
      n_commits++;
      if (sb_q.size() == 0) begin
        check("unexpected_commit", commit_valid, 1'b0);
      end else begin
        pend       = sb_q.pop_front();
        pend_vld   = 1'b1;
        read_index = pend.idx;
        #1;
`ifdef BTB_WRITE_BYPASS_EN
        check("bypass_set_in_commit_cycle", read_set, pend.new_set);
`else
        check("precommit_set_in_commit_cycle", read_set, pend.old_set);
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_target = tgt;
    update_taken  = tk;
    model_update(pc, tgt, tk);
    tick();
  endtask

  task automatic idle(input int n);
    update_valid = 1'b0;
    read_hit     = 1'b0;
    flush        = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic peek(input logic [2:0] idx, output logic [127:0] val);
    read_index = idx;
    #1;
    val = read_set;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_commit_valid", commit_valid, 1'b0);
    read_index = 3'd1;
    #1;
    check("rst_read_set", read_set, 128'b0);
    sb_q.delete();
    pend_vld = 1'b0;
    for (int i = 0; i < 8; i++) m_arr[i] = '0;
    m_lru = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    sync();
  endtask

  initial begin
    rst           = 1'b0;
    update_valid  = 1'b0;
    update_pc     = '0;
    update_target = '0;
    update_taken  = 1'b0;
    flush         = 1'b0;
    read_index    = '0;
    read_hit      = 1'b0;
    next_LRU_read = 1'b0;
    sync();
    do_reset();

    check("reset_lru", LRU, 8'h00);
    check("reset_commit_valid", commit_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      peek(i[2:0], s);
      check($sformatf("reset_set[%0d]", i), s, 128'b0);
    end
    sync();

    // First allocation into set 1.
    issue(32'h0000_0104, 32'h0000_0200, 1'b1);
    idle(3);
    peek(3'd1, s);
    check("alloc_valid", s[127], 1'b1);
    check("alloc_tag", s[126:100], 27'h000_0008);
    check("alloc_target", s[99:68], 32'h0000_0200);
    check("alloc_state", s[67:66], 2'b11);
    check("alloc_lru1", LRU[1], 1'b0);
    check("alloc_commit_count", n_commits, 1);
    sync();

    // Saturating up, then down; not-taken hits keep the target.
    repeat (4) issue(32'h0000_0104, 32'h0000_0200, 1'b1);
    repeat (3) issue(32'h0000_0104, 32'h0000_0999, 1'b0);
    idle(3);
    peek(3'd1, s);
    check("state_after_down", s[67:66], 2'b00);
    check("target_kept_on_not_taken", s[99:68], 32'h0000_0200);
    sync();

    // Forwarding: from 01, two back-to-back taken updates must reach 10.
    issue(32'h0000_0104, 32'h0000_0300, 1'b1);
    idle(3);
    peek(3'd1, s);
    check("state_01", s[67:66], 2'b01);
    sync();
    issue(32'h0000_0104, 32'h0000_0300, 1'b1);
    issue(32'h0000_0104, 32'h0000_0300, 1'b1);
    idle(3);
    peek(3'd1, s);
    check("fwd_state", s[67:66], 2'b10);
    check("fwd_target", s[99:68], 32'h0000_0300);
    sync();

    // IF-stage LRU write colliding with a commit to the same set.
    issue(32'h0000_0104, 32'h0000_0300, 1'b1);
    update_valid = 1'b0;
    tick();
    read_hit      = 1'b1;
    read_index    = 3'd1;
    next_LRU_read = 1'b1;
    tick();
    read_hit = 1'b0;
    check("commit_beats_if_lru", LRU[1], 1'b0);
    idle(2);

    // Not-taken miss: no commit, nothing written.
    base_commits = n_commits;
    issue(32'h0000_0108, 32'h0000_0050, 1'b0);
    idle(3);
    check("nt_miss_no_commit", n_commits, base_commits);
    peek(3'd2, s);
    check("nt_miss_set2", s, 128'b0);
    sync();

    // IF-stage LRU write alone.
    read_hit      = 1'b1;
    read_index    = 3'd3;
    next_LRU_read = 1'b1;
    tick();
    read_hit = 1'b0;
    m_lru[3] = 1'b1;
    check("if_lru_write", LRU[3], 1'b1);
    idle(1);

    // Replacement in set 1.
    do_reset();
    issue(32'h0000_0104, 32'h0000_1000, 1'b1);
    issue(32'h0000_0124, 32'h0000_2000, 1'b1);
    idle(3);
    check("lru1_after_second", LRU[1], 1'b1);
    issue(32'h0000_0144, 32'h0000_3000, 1'b1);
    idle(3);
    peek(3'd1, s);
    check("evict_way1_tag", s[126:100], 27'h000_000A);
    check("evict_way2_tag", s[62:36], 27'h000_0009);
    check("lru1_after_evict", LRU[1], 1'b0);
    sync();

    // Flush while a taken update sits in U1.
    do_reset();
    base_commits = n_commits;
    issue(32'h0000_010C, 32'h0000_4000, 1'b1);
    update_valid = 1'b0;
    flush        = 1'b1;
    sb_q.delete();
    for (int i = 0; i < 8; i++) begin
      m_arr[i][127] = 1'b0;
      m_arr[i][63]  = 1'b0;
    end
    m_lru = '0;
    tick();
    idle(3);
    check("flush_no_commit", n_commits, base_commits);
    check("flush_lru", LRU, 8'h00);
    for (int i = 0; i < 8; i++) begin
      peek(i[2:0], s);
      check($sformatf("flush_valids[%0d]", i), {s[127], s[63]}, 2'b00);
    end
    sync();

    // Reset pulsed while the update is in U2.
    do_reset();
    base_commits = n_commits;
    issue(32'h0000_0104, 32'h0000_5000, 1'b1);
    update_valid = 1'b0;
    tick();
    check("in_u2_before_rst", commit_valid, 1'b1);
    do_reset();
    idle(3);
    check("rst_mid_u2_no_commit", n_commits, base_commits);
    peek(3'd1, s);
    check("rst_mid_u2_set1", s, 128'b0);
    sync();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
